// File: rtl/sdram_port_pkg.sv
// Shared types and constants for the CPU-side SDRAM port bridge.
// Byte-strobe encodings follow the controller's {hi,lo} order.
package sdram_port_pkg;

  localparam int PORT_AW = 21;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdram_cpu_port_if.sv
// CPU byte bus and SDRAM controller toggle port, each bundled with
// modports for the driving (master) and responding (slave) side.
interface cpu_bus_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [21:0] cpu_a;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        cpu_valid;
  logic        cpu_busy;

  modport master (output cpu_req, cpu_we, cpu_a, cpu_d,
                  input  cpu_q, cpu_valid, cpu_busy);
  modport slave  (input  cpu_req, cpu_we, cpu_a, cpu_d,
                  output cpu_q, cpu_valid, cpu_busy);
endinterface

interface sdram_port_if;
  logic                              port_req;
  logic                              port_ack;
  logic                              port_we;
  logic [sdram_port_pkg::PORT_AW-1:0] port_a;
  logic [1:0]                        port_ds;
  logic [15:0]                       port_d;
  logic [15:0]                       port_q;

  modport master (output port_req, port_we, port_a, port_ds, port_d,
                  input  port_ack, port_q);
  modport slave  (input  port_req, port_we, port_a, port_ds, port_d,
                  output port_ack, port_q);
endinterface

// File: rtl/sdram_word_cache.sv
// One-word read cache: tag, data and valid flag, with a byte-lane
// write-through merge applied when a CPU write hits the cached word.
module sdram_word_cache
  import sdram_port_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1,
  parameter int TAG_W    = PORT_AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [15:0]      data_o,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [15:0]      fill_data_i,
  input  logic             wr_i,
  input  logic             wr_lane_i,
  input  logic [7:0]       wr_byte_i
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;

  assign hit_o = valid_q && (tag_q == lookup_tag_i);

  // With the cache disabled a fill never marks the entry valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= CACHE_EN;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q <= fill_tag_i;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (fill_i) begin
        lane_q <= fill_data_i[gi*8 +: 8];
      end else if (wr_i && hit_o && (wr_lane_i == 1'(gi))) begin
        lane_q <= wr_byte_i;
      end
    end
  end

  assign data_o = {g_lane[1].lane_q, g_lane[0].lane_q};

endmodule

// File: rtl/sdram_cpu_port.sv
// Bridges the 8-bit CPU bus onto a 16-bit toggle req/ack SDRAM port,
// with byte-lane steering, a one-word read cache and a busy line.
module sdram_cpu_port
  import sdram_port_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1,
  parameter bit BANK_HI  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  cpu_bus_if.slave     cpu,
  sdram_port_if.master port
);

  localparam int TAG_W = PORT_AW + 1;

  state_e               state_q, state_d;
  logic                 port_req_q = 1'b0;
  logic                 port_req_d;
  logic                 port_we_q, port_we_d;
  logic [1:0]           port_ds_q, port_ds_d;
  logic [PORT_AW-1:0]   port_a_q, port_a_d;
  logic [15:0]          port_d_q, port_d_d;
  logic                 lane_q, lane_d;
  logic [7:0]           cpu_q_q, cpu_q_d;
  logic                 cpu_valid_q, cpu_valid_d;

  logic                 busy;
  logic                 ack_match;
  logic                 cache_hit;
  logic [15:0]          cache_data;
  logic                 cache_fill;
  logic                 cache_wr;

  assign ack_match = (port.port_ack == port_req_q);
  assign busy      = (state_q != IDLE) || !ack_match;

  sdram_word_cache #(
    .CACHE_EN (CACHE_EN),
    .TAG_W    (TAG_W)
  ) u_cache (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag_i ({BANK_HI, cpu.cpu_a[21:1]}),
    .hit_o        (cache_hit),
    .data_o       (cache_data),
    .fill_i       (cache_fill),
    .fill_tag_i   ({BANK_HI, port_a_q}),
    .fill_data_i  (port.port_q),
    .wr_i         (cache_wr),
    .wr_lane_i    (cpu.cpu_a[0]),
    .wr_byte_i    (cpu.cpu_d)
  );

  always_comb begin
    state_d     = state_q;
    port_req_d  = port_req_q;
    port_we_d   = port_we_q;
    port_ds_d   = port_ds_q;
    port_a_d    = port_a_q;
    port_d_d    = port_d_q;
    lane_d      = lane_q;
    cpu_q_d     = cpu_q_q;
    cpu_valid_d = 1'b0;
    cache_fill  = 1'b0;
    cache_wr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu.cpu_req && !busy) begin
          if (cpu.cpu_we) begin
            port_we_d  = 1'b1;
            port_ds_d  = cpu.cpu_a[0] ? DS_HI : DS_LO;
            port_a_d   = cpu.cpu_a[21:1];
            port_d_d   = {cpu.cpu_d, cpu.cpu_d};
            port_req_d = ~port_req_q;
            cache_wr   = 1'b1;
            state_d    = WR_WAIT;
          end else if (cache_hit) begin
            cpu_q_d     = lane_byte(cache_data, cpu.cpu_a[0]);
            cpu_valid_d = 1'b1;
          end else begin
            port_we_d  = 1'b0;
            port_ds_d  = DS_WORD;
            port_a_d   = cpu.cpu_a[21:1];
            port_req_d = ~port_req_q;
            lane_d     = cpu.cpu_a[0];
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (ack_match) begin
          cache_fill  = 1'b1;
          cpu_q_d     = lane_byte(port.port_q, lane_q);
          cpu_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_WAIT: begin
        if (ack_match) begin
          port_we_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      port_we_q   <= 1'b0;
      port_ds_q   <= 2'b00;
      port_a_q    <= '0;
      port_d_q    <= '0;
      lane_q      <= 1'b0;
      cpu_q_q     <= '0;
      cpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_we_q   <= port_we_d;
      port_ds_q   <= port_ds_d;
      port_a_q    <= port_a_d;
      port_d_q    <= port_d_d;
      lane_q      <= lane_d;
      cpu_q_q     <= cpu_q_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  // The request toggle survives reset so an in-flight transfer is
  // neither lost nor re-issued; busy tracks it until ack catches up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      port_req_q <= port_req_d;
    end
  end

  assign cpu.cpu_q     = cpu_q_q;
  assign cpu.cpu_valid = cpu_valid_q;
  assign cpu.cpu_busy  = busy;

  assign port.port_req = port_req_q;
  assign port.port_we  = port_we_q;
  assign port.port_a   = port_a_q;
  assign port.port_ds  = port_ds_q;
  assign port.port_d   = port_d_q;

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Bench for sdram_cpu_port: instance 0 with the cache, instance 1 without,
// each behind a delayed toggle-ack controller model with its own memory.
module tb_sdram_cpu_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic        cpu_req   [2] = '{1'b0, 1'b0};
  logic        cpu_we    [2] = '{1'b0, 1'b0};
  logic [21:0] cpu_a     [2] = '{22'h0, 22'h0};
  logic [7:0]  cpu_d     [2] = '{8'h0, 8'h0};
  logic [7:0]  cpu_q     [2];
  logic        cpu_valid [2];
  logic        cpu_busy  [2];
  logic        port_req  [2];
  logic        port_we   [2];
  logic [20:0] port_a    [2];
  logic [1:0]  port_ds   [2];
  logic [15:0] port_d    [2];
  logic        port_ack  [2] = '{1'b0, 1'b0};
  logic [15:0] port_q    [2] = '{16'h0, 16'h0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    cpu_bus_if    cb ();
    sdram_port_if pb ();

    assign cb.cpu_req    = cpu_req[gi];
    assign cb.cpu_we     = cpu_we[gi];
    assign cb.cpu_a      = cpu_a[gi];
    assign cb.cpu_d      = cpu_d[gi];
    assign cpu_q[gi]     = cb.cpu_q;
    assign cpu_valid[gi] = cb.cpu_valid;
    assign cpu_busy[gi]  = cb.cpu_busy;
    assign pb.port_ack   = port_ack[gi];
    assign pb.port_q     = port_q[gi];
    assign port_req[gi]  = pb.port_req;
    assign port_we[gi]   = pb.port_we;
    assign port_a[gi]    = pb.port_a;
    assign port_ds[gi]   = pb.port_ds;
    assign port_d[gi]    = pb.port_d;

    sdram_cpu_port #(
      .CACHE_EN (gi == 0),
      .BANK_HI  (1'b0)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .cpu   (cb.slave),
      .port  (pb.master)
    );
  end

  // ---------------- controller model ----------------
  int          ctl_delay [2] = '{6, 6};
  int          ctl_wait  [2] = '{0, 0};
  int          toggles   [2] = '{0, 0};
  logic        req_prev  [2] = '{1'b0, 1'b0};
  logic [15:0] mem       [2][4096];
  logic        mem_wr    [2][4096] = '{default: 1'b0};

  // Memory contents before any write; word 0x080 holds 16'hBEEF.
  function automatic logic [15:0] init_word(input logic [11:0] idx);
    if (idx == 12'h080) return 16'hBEEF;
    return (16'(idx) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_word(input int i, input logic [11:0] idx);
    return mem_wr[i][idx] ? mem[i][idx] : init_word(idx);
  endfunction

  function automatic logic [15:0] mem_merge(input int i, input logic [11:0] idx,
                                            input logic [1:0] ds, input logic [15:0] d);
    logic [15:0] w;
    w = mem_word(i, idx);
    if (ds[0]) w[7:0]  = d[7:0];
    if (ds[1]) w[15:8] = d[15:8];
    return w;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (port_req[i] != req_prev[i]) toggles[i] <= toggles[i] + 1;
      req_prev[i] <= port_req[i];
      if (port_req[i] != port_ack[i]) begin
        if (ctl_wait[i] + 1 >= ctl_delay[i]) begin
          if (port_we[i]) begin
            mem[i][port_a[i][11:0]]    <= mem_merge(i, port_a[i][11:0], port_ds[i], port_d[i]);
            mem_wr[i][port_a[i][11:0]] <= 1'b1;
          end else begin
            port_q[i] <= mem_word(i, port_a[i][11:0]);
          end
          port_ack[i] <= port_req[i];
          ctl_wait[i] <= 0;
        end else begin
          ctl_wait[i] <= ctl_wait[i] + 1;
        end
      end else begin
        ctl_wait[i] <= 0;
      end
    end
  end

  // ---------------- reference model (byte addressed) ----------------
  logic [7:0] ref_mem [int];
  logic       ref_valid [2] = '{1'b0, 1'b0};
  logic [20:0] ref_tag  [2] = '{21'h0, 21'h0};

  function automatic logic [7:0] ref_byte(input int i, input logic [21:0] a);
    int k;
    logic [15:0] w;
    k = i * (1 << 22) + int'(a);
    if (ref_mem.exists(k)) return ref_mem[k];
    w = init_word(a[12:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int i, input bit we, input logic [21:0] a, input logic [7:0] d,
                        output logic [7:0] q, output int tog, output int lat, output int bcyc,
                        output logic [1:0] ds, output logic [20:0] pa, output logic [15:0] pd,
                        output logic pwe, output logic vpost, output logic qhold, output bit tmo);
    int n;
    int t0;
    tmo = 0; q = 8'h0; lat = 0; bcyc = 0; n = 0;
    while (cpu_busy[i] && n < 200) begin tick(); n++; end
    if (cpu_busy[i]) tmo = 1;
    t0 = toggles[i];
    cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_a[i] = a; cpu_d[i] = d;
    tick();
    cpu_req[i] = 1'b0;
    lat = 1;
    ds = port_ds[i]; pa = port_a[i]; pd = port_d[i]; pwe = port_we[i];
    if (cpu_busy[i]) bcyc++;
    if (!we) begin
      while (!cpu_valid[i] && lat < 200) begin
        tick(); lat++;
        if (cpu_busy[i]) bcyc++;
      end
      if (!cpu_valid[i]) tmo = 1;
      q = cpu_q[i];
    end else begin
      while (cpu_busy[i] && lat < 200) begin
        tick(); lat++;
        if (cpu_busy[i]) bcyc++;
      end
      if (cpu_busy[i]) tmo = 1;
    end
    tick();
    vpost = cpu_valid[i];
    qhold = (cpu_q[i] == q);
    tog = toggles[i] - t0;
    if (we) ref_mem[i * (1 << 22) + int'(a)] = d;
    $display("TXN inst=%0d we=%0d a=%06h d=%02h q=%02h toggles=%0d lat=%0d busy_cycles=%0d",
             i, we, a, d, q, tog, lat, bcyc);
  endtask

  typedef struct {
    int          inst;
    bit          we;
    logic [21:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_q;
    int          exp_tog;
    logic [1:0]  exp_ds;
    logic [15:0] exp_pd;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    logic [7:0]  q;
    int          tog, lat, bcyc;
    logic [1:0]  ds;
    logic [20:0] pa;
    logic [15:0] pd;
    logic        pwe, vpost, qhold;
    bit          tmo;
    int          t0, n, vcount;
    logic [20:0] pool [8];
    int          i;
    bit          we;
    logic [21:0] a;
    logic [7:0]  d, exp_q;
    bit          hit;

    vecs[0] = '{0, 1'b0, 22'h000101, 8'h00, 8'hBE, 1, 2'b11, 16'h0000};
    vecs[1] = '{0, 1'b0, 22'h000100, 8'h00, 8'hEF, 0, 2'b00, 16'h0000};
    vecs[2] = '{0, 1'b1, 22'h000100, 8'h55, 8'h00, 1, 2'b01, 16'h5555};
    vecs[3] = '{0, 1'b0, 22'h000101, 8'h00, 8'hBE, 0, 2'b00, 16'h0000};
    vecs[4] = '{0, 1'b0, 22'h000100, 8'h00, 8'h55, 0, 2'b00, 16'h0000};
    vecs[5] = '{1, 1'b0, 22'h000101, 8'h00, 8'hBE, 1, 2'b11, 16'h0000};
    vecs[6] = '{1, 1'b0, 22'h000101, 8'h00, 8'hBE, 1, 2'b11, 16'h0000};

    // Reset values
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(cpu_valid[k]), 0);
      check($sformatf("rst_q%0d", k),     32'(cpu_q[k]), 0);
      check($sformatf("rst_busy%0d", k),  32'(cpu_busy[k]), 0);
      check($sformatf("rst_ds%0d", k),    32'(port_ds[k]), 0);
      check($sformatf("rst_we%0d", k),    32'(port_we[k]), 0);
      check($sformatf("rst_a%0d", k),     32'(port_a[k]), 0);
      check($sformatf("rst_d%0d", k),     32'(port_d[k]), 0);
      check($sformatf("rst_req%0d", k),   32'(port_req[k]), 0);
    end
    reset = 1'b0;
    tick();

    // Directed vectors: miss, hit, write-through, cache-disabled reads
    for (int k = 0; k < 7; k++) begin
      access(vecs[k].inst, vecs[k].we, vecs[k].a, vecs[k].d, q, tog, lat, bcyc,
             ds, pa, pd, pwe, vpost, qhold, tmo);
      check($sformatf("v%0d_timeout", k), 32'(tmo), 0);
      check($sformatf("v%0d_toggles", k), 32'(tog), 32'(vecs[k].exp_tog));
      if (!vecs[k].we) begin
        check($sformatf("v%0d_q", k), 32'(q), 32'(vecs[k].exp_q));
        check($sformatf("v%0d_valid_width", k), 32'(vpost), 0);
        check($sformatf("v%0d_q_hold", k), 32'(qhold), 1);
      end
      if (vecs[k].exp_tog == 1) begin
        check($sformatf("v%0d_ds", k), 32'(ds), 32'(vecs[k].exp_ds));
        check($sformatf("v%0d_port_a", k), 32'(pa), 32'(vecs[k].a[21:1]));
        check($sformatf("v%0d_port_we", k), 32'(pwe), 32'(vecs[k].we));
        if (vecs[k].we) check($sformatf("v%0d_port_d", k), 32'(pd), 32'(vecs[k].exp_pd));
        else check($sformatf("v%0d_busy_ge6", k), 32'(bcyc >= 6), 1);
      end else begin
        check($sformatf("v%0d_hit_lat", k), 32'(lat), 1);
        check($sformatf("v%0d_hit_busy", k), 32'(bcyc), 0);
      end
    end

    // Request while busy is dropped
    ctl_delay[0] = 6;
    t0 = toggles[0];
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_a[0] = 22'h000400;
    tick(); cpu_req[0] = 1'b0;
    tick();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_a[0] = 22'h000800; cpu_d[0] = 8'h77;
    tick(); cpu_req[0] = 1'b0;
    check("drop_busy", 32'(cpu_busy[0]), 1);
    check("drop_port_a", 32'(port_a[0]), 32'h200);
    check("drop_port_we", 32'(port_we[0]), 0);
    n = 0;
    while (!cpu_valid[0] && n < 200) begin tick(); n++; end
    check("drop_valid_seen", 32'(cpu_valid[0]), 1);
    check("drop_q", 32'(cpu_q[0]), 32'(ref_byte(0, 22'h000400)));
    tick(); tick(); tick();
    check("drop_toggles", 32'(toggles[0] - t0), 1);
    check("drop_idle", 32'(cpu_busy[0]), 0);
    access(0, 1'b0, 22'h000800, 8'h00, q, tog, lat, bcyc, ds, pa, pd, pwe, vpost, qhold, tmo);
    check("drop_no_write", 32'(q), 32'(ref_byte(0, 22'h000800)));

    // Reset landing in RD_WAIT with a slow ack
    ctl_delay[0] = 4;
    t0 = toggles[0];
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_a[0] = 22'h000C00;
    tick(); cpu_req[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(cpu_busy[0]), 1);
    check("rstmid_ds", 32'(port_ds[0]), 0);
    n = 0; vcount = 0;
    while (cpu_busy[0] && n < 50) begin
      tick(); n++;
      if (cpu_valid[0]) vcount++;
    end
    check("rstmid_busy_clears", 32'(cpu_busy[0]), 0);
    check("rstmid_no_valid", 32'(vcount), 0);
    tick(); tick();
    check("rstmid_no_retoggle", 32'(toggles[0] - t0), 1);
    access(0, 1'b0, 22'h000800, 8'h00, q, tog, lat, bcyc, ds, pa, pd, pwe, vpost, qhold, tmo);
    check("rstmid_cache_invalid", 32'(tog), 1);
    check("rstmid_q", 32'(q), 32'(ref_byte(0, 22'h000800)));

    // Randomized traffic against the reference model
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    ref_valid[0] = 1'b0; ref_valid[1] = 1'b0;
    for (int j = 0; j < 8; j++) pool[j] = {9'($urandom), 12'(12'h300 + j)};
    for (int it = 0; it < 160; it++) begin
      i  = $urandom_range(0, 1);
      we = ($urandom_range(0, 2) == 0);
      a  = {pool[$urandom_range(0, 7)], 1'($urandom)};
      d  = 8'($urandom);
      ctl_delay[i] = $urandom_range(0, 5);
      exp_q = ref_byte(i, a);
      hit   = (i == 0) && ref_valid[0] && (ref_tag[0] == a[21:1]);
      access(i, we, a, d, q, tog, lat, bcyc, ds, pa, pd, pwe, vpost, qhold, tmo);
      check($sformatf("r%0d_timeout", it), 32'(tmo), 0);
      if (we) begin
        check($sformatf("r%0d_wr_toggles", it), 32'(tog), 1);
        check($sformatf("r%0d_wr_ds", it), 32'(ds), a[0] ? 32'h2 : 32'h1);
      end else begin
        check($sformatf("r%0d_q", it), 32'(q), 32'(exp_q));
        check($sformatf("r%0d_rd_toggles", it), 32'(tog), hit ? 0 : 1);
        if (!hit && i == 0) begin
          ref_valid[0] = 1'b1;
          ref_tag[0]   = a[21:1];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
